// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// Upstream feeder for the 2x2 matrix multiplier. Collects eight elements
// (a11,a12,a21,a22,b11,b12,b21,b22) over a valid/ready stream, packs them into
// mat_a/mat_b and holds the pair until downstream consumes it.
// Optional feature macro: LOADER_RANGE_CHECK_EN. When it is defined, an element
// above MAX_VAL rejects the whole frame. The rest of that frame is drained, err
// pulses once and err_cnt counts the rejected frame.
module matrix_operand_loader #(
   parameter int ELEM_W  = 2,
   parameter int MAX_VAL = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ELEM_W-1:0]   in_data,
   input  logic                abort,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*ELEM_W-1:0] mat_a,
   output logic [4*ELEM_W-1:0] mat_b,
   output logic                err,
   output logic [7:0]          err_cnt
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [2:0]        idx_r;
   logic [ELEM_W-1:0] slot_r [8];

   logic accept_s;
   logic last_s;
   logic range_bad_s;
   logic write_s;
   logic in_ready_s;
   logic out_valid_s;

   // True when an element value lies above the legal maximum
   function automatic logic out_of_range(input logic [ELEM_W-1:0] value);
      return (int'(value) > MAX_VAL);
   endfunction

`ifdef LOADER_RANGE_CHECK_EN
   assign range_bad_s = out_of_range(in_data);
`else
   assign range_bad_s = 1'b0;
`endif

   assign accept_s = in_valid && in_ready_s;
   assign last_s   = (idx_r == 3'd7);
   // Only clean elements accepted while loading are stored; abort wins over the write
   assign write_s  = accept_s && (state_r == ST_LOAD) && !range_bad_s && !abort;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_LOAD;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; abort restarts the frame from any state
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = ST_LOAD;
      end else begin
         case (state_r)
            ST_LOAD: begin
               if (accept_s && range_bad_s) begin
                  // A bad final element has nothing left to drain
                  state_nxt_s = last_s ? ST_LOAD : ST_DRAIN;
               end else if (accept_s && last_s) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_nxt_s = ST_LOAD;
               end else begin
                  state_nxt_s = ST_HOLD;
               end
            end
            ST_DRAIN: begin
               if (accept_s && last_s) begin
                  state_nxt_s = ST_LOAD;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end
            default: begin
               state_nxt_s = ST_LOAD;
            end
         endcase
      end
   end

   // Handshake outputs decoded from the state register only
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         ST_LOAD: begin
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
         end
         ST_HOLD: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b1;
         end
         ST_DRAIN: begin
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;

   // Element index: advances on every accept (stored or drained), cleared by abort
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_r <= 3'd0;
      end else if (abort) begin
         idx_r <= 3'd0;
      end else if (accept_s) begin
         idx_r <= idx_r + 3'd1;
      end else begin
         idx_r <= idx_r;
      end
   end

   // Operand slots; contents stay frozen while the pair is held
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            slot_r[i] <= '0;
         end
      end else if (write_s) begin
         slot_r[idx_r] <= in_data;
      end else begin
         slot_r <= slot_r;
      end
   end

   assign mat_a = {slot_r[3], slot_r[2], slot_r[1], slot_r[0]};
   assign mat_b = {slot_r[7], slot_r[6], slot_r[5], slot_r[4]};

`ifdef LOADER_RANGE_CHECK_EN
   logic       reject_s;
   logic       err_r;
   logic [7:0] err_cnt_r;

   // Only the first bad element of a frame rejects it; later ones are drained silently
   assign reject_s = accept_s && (state_r == ST_LOAD) && range_bad_s && !abort;

   // Error pulse and saturating rejected-frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r     <= 1'b0;
         err_cnt_r <= 8'd0;
      end else begin
         err_r <= reject_s;
         if (reject_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end else begin
            err_cnt_r <= err_cnt_r;
         end
      end
   end

   assign err     = err_r;
   assign err_cnt = err_cnt_r;
`else
   assign err     = 1'b0;
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader. Runs directed frames and then
// random traffic. A frame-level reference model predicts the output pairs and
// the handshake and error outputs. It works under both builds of
// LOADER_RANGE_CHECK_EN.
module tb_matrix_operand_loader;

   localparam int W    = 2;
   localparam int MAXV = 2;
`ifdef LOADER_RANGE_CHECK_EN
   localparam bit RANGE = 1'b1;
`else
   localparam bit RANGE = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic           abort;
   logic           out_valid;
   logic           out_ready;
   logic [4*W-1:0] mat_a;
   logic [4*W-1:0] mat_b;
   logic           err;
   logic [7:0]     err_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state (next-edge prediction) and expected visible outputs
   bit             m_hold   = 1'b0;
   bit             m_bad    = 1'b0;
   logic [7:0]     m_errcnt = 8'd0;
   bit             nxt_err  = 1'b0;
   bit             nxt_zero = 1'b0;
   bit             exp_hold = 1'b0;
   bit             exp_err  = 1'b0;
   bit             exp_zero = 1'b0;
   logic [7:0]     exp_errcnt = 8'd0;
   bit             en       = 1'b0;
   bit             seen_rst = 1'b0;
   int             m_elems[$];
   logic [8*W-1:0] sb[$];
   logic [8*W-1:0] head;

   matrix_operand_loader #(.ELEM_W(W), .MAX_VAL(MAXV)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .abort    (abort),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .mat_a    (mat_a),
      .mat_b    (mat_b),
      .err      (err),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: publish expectations for this cycle, drive inputs, predict the next edge
   task automatic step(input bit rst, input bit v, input bit ab, input bit ordy, input int d);
      logic [8*W-1:0] fv;
      @(posedge clk);
      #1;
      exp_hold   = m_hold;
      exp_err    = nxt_err;
      exp_errcnt = m_errcnt;
      exp_zero   = nxt_zero;
      if (seen_rst) en = 1'b1;
      if (rst) seen_rst = 1'b1;
      reset     = rst;
      in_valid  = v;
      abort     = ab;
      out_ready = ordy;
      in_data   = W'(d);
      nxt_err   = 1'b0;
      nxt_zero  = 1'b0;
      if (rst) begin
         m_hold = 1'b0; m_bad = 1'b0; m_elems.delete(); m_errcnt = 8'd0; nxt_zero = 1'b1;
      end else if (ab) begin
         m_hold = 1'b0; m_bad = 1'b0; m_elems.delete();
      end else if (m_hold) begin
         if (ordy) m_hold = 1'b0;
      end else if (v) begin
         if (RANGE && (d > MAXV) && !m_bad) begin
            nxt_err = 1'b1;
            m_bad   = 1'b1;
            if (m_errcnt != 8'd255) m_errcnt = m_errcnt + 8'd1;
         end
         m_elems.push_back(d);
         if (m_elems.size() == 8) begin
            if (!m_bad) begin
               fv = '0;
               for (int i = 0; i < 8; i++) fv |= (8*W)'(m_elems[i]) << (i*W);
               sb.push_back(fv);
               m_hold = 1'b1;
            end
            m_elems.delete();
            m_bad = 1'b0;
         end
      end
   endtask

   task automatic send8(input int e[8], input bit ordy);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, ordy, e[i]);
   endtask

   // Monitor: compare visible outputs mid-cycle, retire the held frame on handshake/drop
   always @(negedge clk) begin
      if (en) begin
         chk("in_ready", 32'(in_ready), 32'(!exp_hold));
         chk("out_valid", 32'(out_valid), 32'(exp_hold));
         chk("err", 32'(err), 32'(exp_err));
         chk("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
         if (exp_zero) begin
            chk("mat_a_reset", 32'(mat_a), 32'd0);
            chk("mat_b_reset", 32'(mat_b), 32'd0);
         end
         if (exp_hold) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_empty: got out_valid with no expected frame at %0t", $time);
            end else begin
               head = sb[0];
               chk("mat_a", 32'(mat_a), 32'(head[4*W-1:0]));
               chk("mat_b", 32'(mat_b), 32'(head[8*W-1:4*W]));
               if (reset || abort || out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      int fr[8];
      reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; in_data = '0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0, 0);

      // Back-to-back frame, then a 5-cycle stall in HOLD with in_valid high
      fr = '{1, 2, 0, 1, 2, 2, 1, 0};
      send8(fr, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 3);
      step(1'b0, 1'b1, 1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Out-of-range third element, then a clean frame
      fr = '{0, 1, 3, 1, 2, 0, 1, 2};
      send8(fr, 1'b1);
      fr = '{2, 1, 0, 2, 1, 0, 2, 1};
      send8(fr, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // All-3s frame, including a bad final element
      fr = '{3, 3, 3, 3, 3, 3, 3, 3};
      send8(fr, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      fr = '{1, 1, 1, 1, 1, 1, 1, 3};
      send8(fr, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Abort after four accepts, then a fresh frame
      repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 2);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3);
      fr = '{0, 1, 2, 0, 1, 2, 0, 1};
      send8(fr, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // Abort while holding, beating a same-cycle out_ready
      fr = '{2, 2, 1, 1, 0, 0, 2, 1};
      send8(fr, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Reset while holding
      fr = '{1, 0, 2, 2, 0, 1, 1, 2};
      send8(fr, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 299) == 0, ($urandom % 4) != 0, $urandom_range(0, 24) == 0,
              ($urandom % 2) == 1, int'($urandom_range(0, 3)));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
